logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single two-input gate modules in the guide exercises.
- Applies one of eight bitwise gate operations to two WIDTH-bit operands and returns the result through a valid/ready output register.
- In accumulate mode it folds several input beats into one result frame, then emits the folded result.
- Serves as the reusable gate stage for later guide datapaths.

---
 rtl/logic_unit_pkg.sv | 39 +++
 rtl/logic_unit_pipe_gate_array.sv | 28 ++
 rtl/logic_unit_pipe.sv | 122 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcodes, FSM state and fold classification
// for the registered bitwise gate stage.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  typedef enum logic [1:0] {
    F_AND,
    F_OR,
    F_XOR,
    F_LAST
  } fold_t;

  function automatic fold_t fold_class(
    input logic [2:0] op
  );
    fold_t f;
    unique case (op)
      OP_AND,  OP_NAND: f = F_AND;
      OP_OR,   OP_NOR:  f = F_OR;
      OP_XOR,  OP_XNOR: f = F_XOR;
      default:          f = F_LAST;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_gate_array.sv
// Combinational WIDTH-bit bitwise gate selected by op.
// Used for beat results and for folding into the accumulator.
module gate_array
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered gate stage with valid/ready output and
// optional multi-beat accumulate frames.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_red,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       frame_op;

  logic             xfer;
  logic [2:0]       cur_op;
  logic [2:0]       fold_op;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] folded;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [2:0] red3(
    input logic [WIDTH-1:0] v
  );
    return {&v, |v, ^v};
  endfunction

  assign in_ready = !out_valid | out_ready;
  assign xfer     = in_valid & in_ready;
  assign cur_op   = (state == ACC) ? frame_op : op;
  assign cnt_nxt  = cnt + CNT_W'(1);

  // Fold reuses the gate: AND/OR/XOR of r with acc, or pass r
  always_comb begin
    fold_op = OP_PASS;
    unique case (fold_class(frame_op))
      F_AND:   fold_op = OP_AND;
      F_OR:    fold_op = OP_OR;
      F_XOR:   fold_op = OP_XOR;
      default: fold_op = OP_PASS;
    endcase
  end

  gate_array #(.WIDTH(WIDTH)) u_beat (
    .a  (a),
    .b  (b),
    .op (cur_op),
    .y  (r)
  );

  gate_array #(.WIDTH(WIDTH)) u_fold (
    .a  (r),
    .b  (acc),
    .op (fold_op),
    .y  (folded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      frame_op  <= OP_AND;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_red   <= 3'b000;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (!acc_en || in_last) begin
              out_valid <= 1'b1;
              out_y     <= r;
              out_red   <= red3(r);
              out_count <= CNT_W'(1);
              out_ovf   <= 1'b0;
            end else begin
              acc      <= r;
              cnt      <= CNT_W'(1);
              frame_op <= op;
              state    <= ACC;
            end
          end
          default: begin
            acc <= folded;
            cnt <= cnt_nxt;
            if (in_last || cnt_nxt == CNT_W'(MAX_BEATS)) begin
              out_valid <= 1'b1;
              out_y     <= folded;
              out_red   <= red3(folded);
              out_count <= cnt_nxt;
              out_ovf   <= !in_last;
              state     <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed checks of logic_unit_pipe against
// a frame-list reference model.
module tb_logic_unit_pipe;

  localparam int W  = 4;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          acc_en;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;
  logic [2:0]    out_red;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  logic_unit_pipe #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_red   (out_red),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: output register plus list of beat results
  bit           m_valid;
  logic [W-1:0] m_y;
  int           m_cnt;
  bit           m_ovf;
  bit           in_frame;
  int           f_op;
  logic [W-1:0] beats[$];

  function automatic logic [W-1:0] gate(
    input int o, input logic [W-1:0] x, input logic [W-1:0] y
  );
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return ~(x ^ y);
      6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic logic [W-1:0] fold_list(input int o);
    logic [W-1:0] v;
    v = beats[0];
    for (int i = 1; i < beats.size(); i++) begin
      if (o >= 6)         v = beats[i];
      else if (o % 3 == 0) v = v & beats[i];
      else if (o % 3 == 1) v = v | beats[i];
      else                 v = v ^ beats[i];
    end
    return v;
  endfunction

  function automatic logic [2:0] red_of(input logic [W-1:0] v);
    int ones;
    ones = $countones(v);
    return {ones == W, ones != 0, ones % 2 == 1};
  endfunction

  task automatic emit(input logic [W-1:0] v, input int c, input bit o);
    m_valid = 1;
    m_y     = v;
    m_cnt   = c;
    m_ovf   = o;
  endtask

  task automatic check_out();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_y", out_y, m_y);
      chk("out_red", out_red, red_of(m_y));
      chk("out_count", out_count, m_cnt);
      chk("out_ovf", out_ovf, m_ovf);
    end
  endtask

  task automatic step(
    input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
    input int iop, input bit iacc, input bit ilast, input bit ordy
  );
    bit mr;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = 3'(iop);
    acc_en    = iacc;
    in_last   = ilast;
    out_ready = ordy;
    #1;
    mr = !m_valid || ordy;
    chk("in_ready", in_ready, mr);
    if (m_valid && ordy) m_valid = 0;
    if (iv && mr) begin
      if (!in_frame) begin
        if (!iacc || ilast) emit(gate(iop, ia, ib), 1, 0);
        else begin
          in_frame = 1;
          f_op     = iop;
          beats    = {gate(iop, ia, ib)};
        end
      end else begin
        beats.push_back(gate(f_op, ia, ib));
        if (ilast || beats.size() == MB) begin
          emit(fold_list(f_op), beats.size(), !ilast);
          in_frame = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic model_reset();
    m_valid  = 0;
    m_y      = '0;
    m_cnt    = 0;
    m_ovf    = 0;
    in_frame = 0;
    beats    = {};
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n    = 0;
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_y", out_y, 0);
    chk("rst_red", out_red, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [W-1:0] tt [8];

  initial begin
    tt = '{4'b0001, 4'b0111, 4'b0110, 4'b1110,
           4'b1000, 4'b1001, 4'b1100, 4'b0011};
    rst_n = 0; in_valid = 0; a = '0; b = '0; op = '0;
    acc_en = 0; in_last = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Truth table: 0011/0101 covers all four bit pairs
    for (int o = 0; o < 8; o++) begin
      step(1, 4'b0011, 4'b0101, o, 0, 0, 1);
      chk("tt_y", out_y, tt[o]);
      chk("tt_count", out_count, 1);
    end
    step(0, 0, 0, 0, 0, 0, 1);

    step(1, 4'b0011, 4'b0101, 2, 0, 0, 1);
    chk("xor_y", out_y, 4'b0110);
    chk("xor_red", out_red, 3'b010);
    step(0, 0, 0, 0, 0, 0, 1);

    // AND frame of three beats
    step(1, 4'b1111, 4'b1110, 0, 1, 0, 1);
    chk("and_nov1", out_valid, 0);
    step(1, 4'b1101, 4'b1111, 6, 0, 0, 1);
    chk("and_nov2", out_valid, 0);
    step(1, 4'b0111, 4'b1111, 5, 1, 1, 1);
    chk("and_y", out_y, 4'b0100);
    chk("and_count", out_count, 3);
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure then same-cycle drain-and-refill
    step(1, 4'b0011, 4'b0101, 2, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'($urandom), 4'($urandom), 0, 0, 0, 0);
      chk("bp_y", out_y, 4'b0110);
    end
    step(1, 4'b1111, 4'b0000, 7, 0, 0, 1);
    chk("refill_y", out_y, 4'b1111);
    step(0, 0, 0, 0, 0, 0, 1);

    // Overflow at MAX_BEATS, then beat 5 opens a new frame
    step(1, 4'b0001, 0, 1, 1, 0, 1);
    step(1, 4'b0010, 0, 1, 1, 0, 1);
    step(1, 4'b0100, 0, 1, 1, 0, 1);
    step(1, 4'b1000, 0, 1, 1, 0, 1);
    chk("ovf_y", out_y, 4'b1111);
    chk("ovf_count", out_count, 4);
    chk("ovf_flag", out_ovf, 1);
    step(1, 4'b1001, 0, 1, 1, 0, 1);
    chk("ovf_next", out_valid, 0);
    step(1, 4'b0100, 0, 3, 1, 1, 1);
    chk("ovf_next_cnt", out_count, 2);
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset mid-frame
    step(1, 4'b1100, 4'b1010, 2, 1, 0, 1);
    step(1, 4'b0110, 4'b0011, 2, 1, 0, 1);
    do_reset();
    step(1, 4'b1010, 4'b0110, 2, 0, 0, 1);
    chk("post_rst_y", out_y, 4'b1100);
    chk("post_rst_cnt", out_count, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom % 4 != 0, 4'($urandom), 4'($urandom),
           int'($urandom % 8), 1'($urandom % 2),
           $urandom % 4 == 0, $urandom % 3 != 0);
      if ($urandom % 500 == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
